// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Optional op counter is enabled by defining ALU_SEQ_STATS_EN.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 3;
  localparam int CNT_W      = 4;   // settle counter, holds SETTLE_CYCLES-1 (0..14)
  localparam int STATS_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    RESP   = 2'b10
  } seq_state_e;

  // Debug view of the sequencer FSM for checkers and waveforms.
  typedef struct packed {
    seq_state_e          state;
    logic [CNT_W-1:0]    settle_cnt;
  } seq_dbg_t;

  // Opcode encoding shared with the combinational ALU.
  localparam logic [OP_W_DEF-1:0] OP_ADD   = 3'd0;
  localparam logic [OP_W_DEF-1:0] OP_SUB   = 3'd1;
  localparam logic [OP_W_DEF-1:0] OP_AND   = 3'd2;
  localparam logic [OP_W_DEF-1:0] OP_OR    = 3'd3;
  localparam logic [OP_W_DEF-1:0] OP_XOR   = 3'd4;
  localparam logic [OP_W_DEF-1:0] OP_NOT_A = 3'd5;
  localparam logic [OP_W_DEF-1:0] OP_SHL   = 3'd6;
  localparam logic [OP_W_DEF-1:0] OP_SHR   = 3'd7;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU operation sequencer.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the initiator holds valid and payload stable until that edge.
interface alu_op_sequencer_if #(
  parameter int DATA_W = alu_seq_pkg::DATA_W_DEF,
  parameter int OP_W   = alu_seq_pkg::OP_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   req_op;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic              alu_en;
  logic [DATA_W-1:0] alu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [OP_W-1:0]   rsp_op;

  // Sequencer side.
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, alu_en, rsp_valid, rsp_data, rsp_op
  );

  // Command source, ALU and response consumer side.
  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, alu_en, rsp_valid, rsp_data, rsp_op
  );
endinterface

// File: rtl/alu_seq_stats.sv
// Saturating count of completed responses with a synchronous clear.
// Only instantiated when ALU_SEQ_STATS_EN is defined.
module alu_seq_stats #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear takes priority over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Handshaked driver for the combinational ALU: accept op, hold ALU inputs for
// SETTLE_CYCLES, capture result, return it. ALU_SEQ_STATS_EN adds op_count.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int OP_W          = OP_W_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus,
  output seq_dbg_t            dbg
`ifdef ALU_SEQ_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [STATS_W-1:0]  op_count
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e        state_q, state_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic [DATA_W-1:0] a_q, a_nx;
  logic [DATA_W-1:0] b_q, b_nx;
  logic [OP_W-1:0]   op_q, op_nx;
  logic              en_q, en_nx;
  logic              valid_q, valid_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic [OP_W-1:0]   rop_q, rop_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      rop_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      a_q     <= a_nx;
      b_q     <= b_nx;
      op_q    <= op_nx;
      en_q    <= en_nx;
      valid_q <= valid_nx;
      data_q  <= data_nx;
      rop_q   <= rop_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    a_nx     = a_q;
    b_nx     = b_q;
    op_nx    = op_q;
    en_nx    = en_q;
    valid_nx = valid_q;
    data_nx  = data_q;
    rop_nx   = rop_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_nx     = bus.req_a;
          b_nx     = bus.req_b;
          op_nx    = bus.req_op;
          en_nx    = 1'b1;
          cnt_nx   = SETTLE_LOAD;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        // Counter reaching zero marks the SETTLE_CYCLES-th edge after accept.
        if (cnt_q == '0) begin
          data_nx  = bus.alu_result;
          rop_nx   = op_q;
          valid_nx = 1'b1;
          en_nx    = 1'b0;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        en_nx    = 1'b0;
        valid_nx = 1'b0;
      end
    endcase
  end

  // ALU operands stay on their last values while alu_en is low.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_en    = en_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_op    = rop_q;

  assign dbg = {state_q, cnt_q};

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats #(.W(STATS_W)) u_stats (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (valid_q && bus.rsp_ready),
    .clr   (stats_clr),
    .count (op_count)
  );
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: two instances (SETTLE_CYCLES 1 and 4)
// driven by a behavioural ALU; covers ALU_SEQ_STATS_EN when it is defined.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int W  = 8;
  localparam int OW = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- per-instance signals ----------------
  logic          req_valid[2];
  logic [W-1:0]  req_a[2];
  logic [W-1:0]  req_b[2];
  logic [OW-1:0] req_op[2];
  logic          rsp_ready[2];
  logic          req_ready[2];
  logic          alu_en[2];
  logic          rsp_valid[2];
  logic [W-1:0]  alu_a[2];
  logic [W-1:0]  alu_b[2];
  logic [W-1:0]  rsp_data[2];
  logic [OW-1:0] alu_op[2];
  logic [OW-1:0] rsp_op[2];
  seq_dbg_t      dbg[2];
  logic [4:0]    en_cnt[2];
`ifdef ALU_SEQ_STATS_EN
  logic          stats_clr[2];
  logic          clr_req[2];
  logic [15:0]   op_count[2];
`endif

  // ---------------- bench model state ----------------
  int            rdy_mode[2];   // 0: ready high, 1: random, 2: held low
  logic          busy[2];
  logic [W-1:0]  last_a[2];
  logic [W-1:0]  last_b[2];
  logic [OW-1:0] last_op[2];
  logic          prev_valid[2];
  logic [11:0]   exp_q[$];      // {instance, op, result}
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OW-1:0] op);
    logic [W-1:0] r;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT_A: r = ~a;
      OP_SHL:   r = {a[W-2:0], 1'b0};
      default:  r = {1'b0, a[W-1:1]};
    endcase
    return r;
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : 4;
    alu_op_sequencer_if #(.DATA_W(W), .OP_W(OW)) bus ();

    assign bus.req_valid = req_valid[g];
    assign bus.req_a     = req_a[g];
    assign bus.req_b     = req_b[g];
    assign bus.req_op    = req_op[g];
    assign bus.rsp_ready = rsp_ready[g];
    // The ALU model shows a wrong value until the last cycle before capture.
    assign bus.alu_result = (bus.alu_en && (en_cnt[g] == 5'(S - 1)))
                          ? alu_ref(bus.alu_a, bus.alu_b, bus.alu_op)
                          : (alu_ref(bus.alu_a, bus.alu_b, bus.alu_op) ^ 8'hA5);

    assign req_ready[g] = bus.req_ready;
    assign alu_a[g]     = bus.alu_a;
    assign alu_b[g]     = bus.alu_b;
    assign alu_op[g]    = bus.alu_op;
    assign alu_en[g]    = bus.alu_en;
    assign rsp_valid[g] = bus.rsp_valid;
    assign rsp_data[g]  = bus.rsp_data;
    assign rsp_op[g]    = bus.rsp_op;

    alu_op_sequencer #(.DATA_W(W), .OP_W(OW), .SETTLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg       (dbg[g])
`ifdef ALU_SEQ_STATS_EN
      ,
      .stats_clr (stats_clr[g]),
      .op_count  (op_count[g])
`endif
    );
  end

  // Cycles alu_en has been high, as seen at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_cnt[0] <= 5'd0;
      en_cnt[1] <= 5'd0;
    end else begin
      for (int i = 0; i < 2; i++) en_cnt[i] <= alu_en[i] ? en_cnt[i] + 5'd1 : 5'd0;
    end
  end

  // Response consumer: changes rsp_ready shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      case (rdy_mode[i])
        0:       rsp_ready[i] = 1'b1;
        1:       rsp_ready[i] = 1'($urandom_range(0, 1));
        default: rsp_ready[i] = 1'b0;
      endcase
`ifdef ALU_SEQ_STATS_EN
      stats_clr[i] = clr_req[i];
`endif
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name, input int i);
    n_checks++;
    n_fail++;
    $display("FAIL %s[%0d]: wait bound expired at %0t", name, i, $time);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("req_ready", i, 32'(req_ready[i]), 32'(!busy[i]));
        chk("alu_en", i, 32'(alu_en[i]), 32'(busy[i] && !rsp_valid[i]));
        if (!alu_en[i])
          chk("alu_hold", i, 32'({alu_op[i], alu_a[i], alu_b[i]}), 32'({last_op[i], last_a[i], last_b[i]}));
        if (rsp_valid[i] && !prev_valid[i])
          chk("latency", i, 32'(en_cnt[i]), 32'(settle_of(i)));
        if (rsp_valid[i]) begin
          if (exp_q.size() == 0 || exp_q[0][11] != 1'(i)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp[%0d]: got op %h data %h, expected no response", i, rsp_op[i], rsp_data[i]);
            if (rsp_ready[i]) busy[i] = 1'b0;
          end else begin
            chk("rsp", i, 32'({rsp_op[i], rsp_data[i]}), 32'(exp_q[0][10:0]));
            if (rsp_ready[i]) begin
              void'(exp_q.pop_front());
              busy[i] = 1'b0;
            end
          end
        end
        prev_valid[i] = rsp_valid[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the accept edge
  // with req_valid still high so back-to-back calls keep the request asserted.
  task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op);
    int n = 0;
    req_a[i] = a;
    req_b[i] = b;
    req_op[i] = op;
    req_valid[i] = 1'b1;
    while (!req_ready[i] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      bound_fail("accept_timeout", i);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    last_a[i] = a;
    last_b[i] = b;
    last_op[i] = op;
    busy[i] = 1'b1;
    exp_q.push_back({1'(i), op, alu_ref(a, b, op)});
    @(negedge clk);
  endtask

  task automatic idle(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i);
    int n = 0;
    while (!rsp_valid[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[i]) bound_fail("rsp_timeout", i);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      bound_fail("drain_timeout", 0);
      exp_q.delete();
      busy[0] = 1'b0;
      busy[1] = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0;
      last_a[i] = '0;
      last_b[i] = '0;
      last_op[i] = '0;
      prev_valid[i] = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cur;
    int id;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_a[i] = '0;
      req_b[i] = '0;
      req_op[i] = '0;
      rdy_mode[i] = 0;
`ifdef ALU_SEQ_STATS_EN
      clr_req[i] = 1'b0;
`endif
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
      chk("rst_alu_en", i, 32'(alu_en[i]), 32'd0);
      chk("rst_rsp", i, 32'({rsp_valid[i], rsp_op[i], rsp_data[i]}), 32'd0);
    end

    // Single op, SETTLE_CYCLES=1.
    send(0, 8'h11, 8'hFF, OP_ADD);
    idle(0);
    drain();

    // Back-pressure: consumer holds rsp_ready low for 5 cycles.
    rdy_mode[0] = 2;
    send(0, 8'hA9, 8'h90, OP_SUB);
    idle(0);
    wait_rsp(0);
    repeat (5) @(negedge clk);
    chk("bp_hold", 0, 32'({rsp_valid[0], req_ready[0], rsp_op[0], rsp_data[0]}), 32'({1'b1, 1'b0, OP_SUB, 8'h19}));
    rdy_mode[0] = 0;
    drain();

    // SETTLE_CYCLES=4 with an ALU output that is wrong until the last cycle.
    send(1, 8'h11, 8'h24, OP_OR);
    idle(1);
    drain();

    // Request held high across two ops.
    send(0, 8'h35, 8'h0F, OP_XOR);
    send(0, 8'hC3, 8'h3C, OP_AND);
    idle(0);
    drain();

    // Asynchronous reset in the middle of SETTLE.
    send(1, 8'h7E, 8'h01, OP_SUB);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_en", 1, 32'(alu_en[1]), 32'd0);
    chk("abort_valid", 1, 32'(rsp_valid[1]), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1, 8'h80, 8'h00, OP_SHR);
    idle(1);
    drain();

    // Randomized traffic with a random consumer.
    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    cur = 0;
    for (int k = 0; k < 40; k++) begin
      id = $urandom_range(0, 1);
      if (id != cur) begin
        idle(cur);
        drain();
        cur = id;
      end
      send(id, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) begin
        idle(id);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle(0);
    idle(1);
    drain();
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    repeat (2) @(negedge clk);

`ifdef ALU_SEQ_STATS_EN
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cnt_reset", 0, 32'(op_count[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      send(0, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      idle(0);
      drain();
    end
    @(negedge clk);
    chk("cnt_three", 0, 32'(op_count[0]), 32'd3);
    rdy_mode[0] = 2;
    send(0, 8'h05, 8'h03, OP_ADD);
    idle(0);
    wait_rsp(0);
    clr_req[0] = 1'b1;
    rdy_mode[0] = 0;
    @(posedge clk);
    @(negedge clk);
    clr_req[0] = 1'b0;
    @(negedge clk);
    chk("cnt_clr_wins", 0, 32'(op_count[0]), 32'd0);
    drain();
`endif

    chk("queue_empty", 0, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog[0]: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Clocked command-side driver for the 8-bit combinational ALU: accepts operation requests over a valid/ready handshake, drives the ALU operand/opcode/enable inputs, waits a programmable settle time, captures the result, and returns it over a valid/ready response channel.
- Sits between a CPU-style command source and the ALU; replaces ad-hoc stimulus driving of A/B/operation/en with a registered, handshaked initiator.

Parameters:
- DATA_W, 8, operand/result width (matches ALU A, B, alu_out).
- OP_W, 3, opcode width (matches ALU operation).
- SETTLE_CYCLES, 1, cycles ALU inputs are held before result is sampled; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_a  input  DATA_W  operand A.
- req_b  input  DATA_W  operand B.
- req_op  input  OP_W  ALU opcode, passed through unmodified.
- alu_a  output  DATA_W  to ALU A.
- alu_b  output  DATA_W  to ALU B.
- alu_op  output  OP_W  to ALU operation.
- alu_en  output  1  to ALU en.
- alu_result  input  DATA_W  from ALU alu_out.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  DATA_W  captured ALU result.
- rsp_op  output  OP_W  opcode that produced rsp_data.

Behaviour:
- Reset (rst_n low, async): state IDLE; req_ready=1 once released; alu_a=alu_b=0, alu_op=0, alu_en=0; rsp_valid=0, rsp_data=0, rsp_op=0; settle counter 0. Reset mid-operation aborts the op; no response is produced.
- All outputs registered except req_ready, which is decoded from state (req_ready = state==IDLE).
- IDLE: on edge with req_valid && req_ready, latch req_a/b/op into alu_a/b/op, set alu_en=1, load counter with SETTLE_CYCLES-1, go SETTLE. req_* ignored when req_valid low.
- SETTLE: counter decrements each edge; on edge where counter==0, capture alu_result into rsp_data, alu_op into rsp_op, set rsp_valid=1, clear alu_en, go RESP.
- Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the accept edge. alu_en is high for exactly SETTLE_CYCLES cycles.
- RESP: hold rsp_valid/rsp_data/rsp_op stable until rsp_ready sampled high; on that edge clear rsp_valid, go IDLE. rsp_ready high in other states has no effect.
- alu_a/b/op retain their last values after alu_en drops (no toggling while disabled).
- Throughput: one op per SETTLE_CYCLES+2 cycles with rsp_ready tied high; no overlap, no request accepted while in SETTLE or RESP.
- Back-pressure: rsp_ready held low indefinitely stalls in RESP; req_ready stays 0.
- Illegal state encoding recovers to IDLE with alu_en=0, rsp_valid=0.

Optional Feature:
- Macro ALU_SEQ_STATS_EN.
- Defined: adds output op_count (16 bits) and input stats_clr (1 bit). op_count increments by 1 on each response handshake (rsp_valid && rsp_ready), saturates at 16'hFFFF; stats_clr synchronously zeroes it (clear wins over simultaneous increment); reset value 0.
- Undefined: ports and counter absent; core behaviour identical.

Decomposition:
- Shared package alu_seq_pkg: state enum (IDLE, SETTLE, RESP), DATA_W/OP_W defaults, opcode localparams shared with the ALU.
- One sub-module alu_seq_stats (saturating counter with clear), instantiated only under ALU_SEQ_STATS_EN.

Test Plan:
- Single op, SETTLE_CYCLES=1: req a=8'h11 b=8'hFF op=3'b000, bench ALU model returns 8'h10 -> alu_en high 1 cycle, rsp_valid 1 edge after accept, rsp_data=8'h10, rsp_op=3'b000.
- Back-pressure: a=8'hA9 b=8'h90 op=3'b001, rsp_ready low 5 cycles -> rsp_valid/rsp_data stable 5 cycles, req_ready=0 throughout, IDLE after handshake.
- SETTLE_CYCLES=4: request a=8'h11 op=3'b011 -> alu_en high exactly 4 cycles, result sampled on 4th edge; ALU output changed before 4th edge is ignored.
- Request held during busy: req_valid held high across two ops -> second accepted only after first response handshake; 2 responses in order.
- Async reset mid-SETTLE: rst_n low 1 cycle -> alu_en=0, rsp_valid=0 immediately; no response; next request completes normally.
- ALU_SEQ_STATS_EN: 3 completed ops -> op_count=3; stats_clr coincident with 4th handshake -> op_count=0.
